// File: rtl/core_ctrl_pkg.sv
// Shared constants and types for the core_ctrl convolution sequencer:
// inst bit positions, the idle instruction word, FSM states and agen controls.
package core_ctrl_pkg;
  localparam int AW       = 11;
  localparam int NPW      = 7;
  localparam int IW       = 36;
  localparam int COL_DEF  = 8;
  localparam int ROW_DEF  = 8;
  localparam int KSIZE_DEF = 9;

  localparam int B_ACC      = 33;
  localparam int B_P_CEN    = 32;
  localparam int B_P_WEN    = 31;
  localparam int B_P_A      = 20;
  localparam int B_X_CEN    = 19;
  localparam int B_X_WEN    = 18;
  localparam int B_X_A      = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_KLD      = 0;

  // Both SRAMs disabled (active-low CEN/WEN high), everything else quiet.
  localparam logic [IW-1:0] INST_IDLE = 36'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_WLD, S_KLD, S_KDRAIN, S_XLD, S_EXEC, S_ODRAIN, S_ACC, S_DONE
  } state_e;

  typedef struct packed {
    logic ld;
    logic k_step;
    logic xsel;
    logic xoff_clr;
    logic xoff_inc;
    logic poff_clr;
    logic poff_inc;
    logic r_step;
    logic pix_next;
  } agen_ctl_t;
endpackage

// File: rtl/core_ctrl_if.sv
// Host-side start/config/status bundle of core_ctrl.
interface core_ctrl_if;
  import core_ctrl_pkg::*;
  logic           start;
  logic [NPW-1:0] cfg_npix;
  logic [AW-1:0]  cfg_wbase;
  logic [AW-1:0]  cfg_xbase;
  logic [AW-1:0]  cfg_pbase;
  logic           busy;
  logic           done;

  modport master (output start, cfg_npix, cfg_wbase, cfg_xbase, cfg_pbase,
                  input busy, done);
  modport slave  (input start, cfg_npix, cfg_wbase, cfg_xbase, cfg_pbase,
                  output busy, done);
endinterface

// File: rtl/core_ctrl_agen.sv
// Running base/offset address counters for xmem (weights, activations) and
// psum memory (per-k write rows, per-pixel accumulate reads). All wrap mod 2^AW.
module core_ctrl_agen
  import core_ctrl_pkg::*;
#(
  parameter int COL = COL_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  agen_ctl_t       ctl_i,
  input  logic [AW-1:0]   wbase_i,
  input  logic [AW-1:0]   xbase_i,
  input  logic [AW-1:0]   pbase_i,
  input  logic [AW-1:0]   stride_i,
  output logic [AW-1:0]   xaddr_o,
  output logic [AW-1:0]   pwaddr_o,
  output logic [AW-1:0]   praddr_o
);
  localparam logic [AW-1:0] COL_A = AW'(COL);
  localparam logic [AW-1:0] ONE   = AW'(1);

  logic [AW-1:0] wk_q, xk_q, pk_q, xoff_q, poff_q, pix_q, rptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wk_q   <= '0;
      xk_q   <= '0;
      pk_q   <= '0;
      xoff_q <= '0;
      poff_q <= '0;
      pix_q  <= '0;
      rptr_q <= '0;
    end else if (ctl_i.ld) begin
      wk_q   <= wbase_i;
      xk_q   <= xbase_i;
      pk_q   <= pbase_i;
      pix_q  <= pbase_i;
      rptr_q <= pbase_i;
      xoff_q <= '0;
      poff_q <= '0;
    end else begin
      if (ctl_i.k_step) begin
        wk_q <= wk_q + COL_A;
        xk_q <= xk_q + stride_i;
        pk_q <= pk_q + stride_i;
      end
      if (ctl_i.xoff_clr)      xoff_q <= '0;
      else if (ctl_i.xoff_inc) xoff_q <= xoff_q + ONE;
      if (ctl_i.poff_clr)      poff_q <= '0;
      else if (ctl_i.poff_inc) poff_q <= poff_q + ONE;
      // Accumulate reads walk down the k rows of one pixel, then restart at pixel+1.
      if (ctl_i.pix_next) begin
        pix_q  <= pix_q + ONE;
        rptr_q <= pix_q + ONE;
      end else if (ctl_i.r_step) begin
        rptr_q <= rptr_q + stride_i;
      end
    end
  end

  assign xaddr_o  = (ctl_i.xsel ? xk_q : wk_q) + xoff_q;
  assign pwaddr_o = pk_q + poff_q;
  assign praddr_o = rptr_q;
endmodule

// File: rtl/core_ctrl.sv
// Convolution-pass sequencer: drives the registered 36-bit inst word of core
// through weight load, kernel load, activation stream, OFIFO drain and SFP accumulate.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int COL   = COL_DEF,
  parameter int ROW   = ROW_DEF,
  parameter int KSIZE = KSIZE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  core_ctrl_if.slave    host,
  input  logic          ofifo_valid,
  output logic [IW-1:0] inst
);
  localparam int KW = 4;
  localparam logic [NPW-1:0] N1      = NPW'(1);
  localparam logic [NPW-1:0] COL_END = NPW'(COL - 1);
  localparam logic [NPW-1:0] KDR_END = NPW'(ROW + COL - 1);
  localparam logic [KW-1:0]  K1      = KW'(1);
  localparam logic [KW-1:0]  K_END   = KW'(KSIZE - 1);

  state_e         state_q;
  logic [IW-1:0]  inst_q, inst_d;
  logic           busy_q, done_q;
  logic [NPW-1:0] npix_q, cnt_q, rd_cnt_q, wr_cnt_q;
  logic [KW-1:0]  k_q, m_q;
  logic           gap_q, pwr_pend_q, l0wr_pend_q, acc_pend_q;
  logic [AW-1:0]  pwr_addr_q;

  agen_ctl_t     ag;
  logic [AW-1:0] xaddr, pwaddr, praddr;
  logic          rd_ok, last_wr;

  core_ctrl_agen #(.COL(COL)) u_agen (
    .clk     (clk),
    .reset   (reset),
    .ctl_i   (ag),
    .wbase_i (host.cfg_wbase),
    .xbase_i (host.cfg_xbase),
    .pbase_i (host.cfg_pbase),
    .stride_i(AW'(npix_q)),
    .xaddr_o (xaddr),
    .pwaddr_o(pwaddr),
    .praddr_o(praddr)
  );

  // Never pop more OFIFO rows than this kernel position produces.
  assign rd_ok   = (state_q == S_ODRAIN) && ofifo_valid && (rd_cnt_q != npix_q);
  assign last_wr = pwr_pend_q && (wr_cnt_q == npix_q - N1);

  always_comb begin
    ag      = '0;
    ag.xsel = (state_q == S_XLD);
    unique case (state_q)
      S_IDLE:       ag.ld = host.start && (host.cfg_npix != '0);
      S_WLD, S_XLD: ag.xoff_inc = 1'b1;
      S_KDRAIN:     ag.xoff_clr = (cnt_q == KDR_END);
      S_ODRAIN: begin
        ag.poff_inc = rd_ok;
        if (last_wr && (k_q != K_END)) begin
          ag.k_step   = 1'b1;
          ag.xoff_clr = 1'b1;
          ag.poff_clr = 1'b1;
        end
      end
      S_ACC: begin
        ag.pix_next = gap_q;
        ag.r_step   = !gap_q;
      end
      default: ;
    endcase
  end

  // Delayed l0_wr/acc ride on top of whatever the next word is.
  always_comb begin
    inst_d             = INST_IDLE;
    inst_d[B_IFIFO_WR] = 1'b0;
    inst_d[B_IFIFO_RD] = 1'b0;
    inst_d[B_L0_WR]    = l0wr_pend_q;
    inst_d[B_ACC]      = acc_pend_q;
    unique case (state_q)
      S_WLD, S_XLD: begin
        inst_d[B_X_CEN]       = 1'b0;
        inst_d[B_X_A +: AW]   = xaddr;
      end
      S_KLD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_KLD]   = 1'b1;
      end
      S_EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
      end
      S_ODRAIN: begin
        inst_d[B_OFIFO_RD] = rd_ok;
        if (pwr_pend_q) begin
          inst_d[B_P_CEN]     = 1'b0;
          inst_d[B_P_WEN]     = 1'b0;
          inst_d[B_P_A +: AW] = pwr_addr_q;
        end
      end
      S_ACC: begin
        if (!gap_q) begin
          inst_d[B_P_CEN]     = 1'b0;
          inst_d[B_P_A +: AW] = praddr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      inst_q      <= INST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      npix_q      <= '0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      k_q         <= '0;
      m_q         <= '0;
      gap_q       <= 1'b0;
      pwr_pend_q  <= 1'b0;
      pwr_addr_q  <= '0;
      l0wr_pend_q <= 1'b0;
      acc_pend_q  <= 1'b0;
    end else begin
      inst_q      <= inst_d;
      done_q      <= 1'b0;
      l0wr_pend_q <= (state_q == S_WLD) || (state_q == S_XLD);
      acc_pend_q  <= (state_q == S_ACC) && !gap_q;
      pwr_pend_q  <= rd_ok;
      if (rd_ok) pwr_addr_q <= pwaddr;
      unique case (state_q)
        S_IDLE: if (host.start) begin
          busy_q  <= 1'b1;
          npix_q  <= host.cfg_npix;
          k_q     <= '0;
          cnt_q   <= '0;
          state_q <= (host.cfg_npix == '0) ? S_DONE : S_WLD;
        end
        S_WLD: if (cnt_q == COL_END) begin
          cnt_q <= '0; state_q <= S_KLD;
        end else cnt_q <= cnt_q + N1;
        S_KLD: if (cnt_q == COL_END) begin
          cnt_q <= '0; state_q <= S_KDRAIN;
        end else cnt_q <= cnt_q + N1;
        S_KDRAIN: if (cnt_q == KDR_END) begin
          cnt_q <= '0; state_q <= S_XLD;
        end else cnt_q <= cnt_q + N1;
        S_XLD: if (cnt_q == npix_q - N1) begin
          cnt_q <= '0; state_q <= S_EXEC;
        end else cnt_q <= cnt_q + N1;
        S_EXEC: if (cnt_q == npix_q - N1) begin
          cnt_q <= '0; state_q <= S_ODRAIN;
        end else cnt_q <= cnt_q + N1;
        S_ODRAIN: begin
          if (rd_ok)      rd_cnt_q <= rd_cnt_q + N1;
          if (pwr_pend_q) wr_cnt_q <= wr_cnt_q + N1;
          if (last_wr) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            if (k_q == K_END) begin
              cnt_q   <= '0;
              m_q     <= '0;
              gap_q   <= 1'b0;
              state_q <= S_ACC;
            end else begin
              k_q     <= k_q + K1;
              state_q <= S_WLD;
            end
          end
        end
        S_ACC: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            if (cnt_q == npix_q - N1) state_q <= S_DONE;
            else                      cnt_q   <= cnt_q + N1;
          end else if (m_q == K_END) begin
            m_q   <= '0;
            gap_q <= 1'b1;
          end else begin
            m_q <= m_q + K1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst      = inst_q;
  assign host.busy = busy_q;
  assign host.done = done_q;
endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: a ksize=1 and a ksize=9 instance, a table of
// full passes checked against closed-form address lists, plus stall/start/reset corners.
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  typedef logic [AW-1:0] aq_t [$];
  typedef struct {
    bit s;       // 0: ksize=1 instance, 1: ksize=9 instance
    int npix;
    int wb;
    int xb;
    int pb;
    int xlast;   // last xmem read address, hand-computed
    int prlast;  // last psum read address, hand-computed
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ofv_a = 1'b1;
  logic ofv_b = 1'b1;
  logic [IW-1:0] inst_a, inst_b;

  core_ctrl_if ifa();
  core_ctrl_if ifb();

  core_ctrl #(.COL(8), .ROW(8), .KSIZE(1)) dut_a (
    .clk(clk), .reset(reset), .host(ifa), .ofifo_valid(ofv_a), .inst(inst_a));
  core_ctrl #(.COL(8), .ROW(8), .KSIZE(9)) dut_b (
    .clk(clk), .reset(reset), .host(ifb), .ofifo_valid(ofv_b), .inst(inst_b));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit sel = 1'b0;
  aq_t xq, pwq, prq;
  int n_kld, n_exec, n_ofrd, n_done, n_l0wr, n_acc, n_rule;
  logic [IW-1:0] w, prev;

  // Trace of the selected instance; cleared whenever disabled.
  always @(negedge clk) begin
    if (!mon_en) begin
      xq.delete(); pwq.delete(); prq.delete();
      n_kld = 0; n_exec = 0; n_ofrd = 0; n_done = 0;
      n_l0wr = 0; n_acc = 0; n_rule = 0;
      prev = INST_IDLE;
    end else begin
      w = sel ? inst_b : inst_a;
      if (!w[B_X_CEN]) xq.push_back(w[B_X_A +: AW]);
      if (!w[B_P_CEN] && !w[B_P_WEN]) pwq.push_back(w[B_P_A +: AW]);
      if (!w[B_P_CEN] && w[B_P_WEN])  prq.push_back(w[B_P_A +: AW]);
      if (w[B_KLD])      n_kld++;
      if (w[B_EXEC])     n_exec++;
      if (w[B_OFIFO_RD]) n_ofrd++;
      if (w[B_L0_WR])    n_l0wr++;
      if (w[B_ACC])      n_acc++;
      if (sel ? ifb.done : ifa.done) n_done++;
      if (w[B_L0_WR] != !prev[B_X_CEN]) n_rule++;
      if (w[B_ACC] != (!prev[B_P_CEN] && prev[B_P_WEN])) n_rule++;
      if ((!w[B_P_CEN] && !w[B_P_WEN]) != prev[B_OFIFO_RD]) n_rule++;
      if (w[35:34] != 2'b00 || w[5:4] != 2'b00 || !w[B_X_WEN]) n_rule++;
      prev = w;
    end
  end

  task automatic cmp_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_q(input string nm, input aq_t a, input aq_t e);
    int bad = -1;
    n_chk++;
    for (int i = 0; i < a.size() && i < e.size(); i++)
      if (bad < 0 && a[i] !== e[i]) bad = i;
    if (a.size() != e.size() || bad >= 0) begin
      n_fail++;
      if (bad < 0) $display("FAIL %s: got %0d entries, want %0d", nm, a.size(), e.size());
      else $display("FAIL %s: entry %0d got %0d want %0d (sizes %0d/%0d)",
                    nm, bad, a[bad], e[bad], a.size(), e.size());
    end
  endtask

  task automatic drive(input bit s, input logic st, input int np, input int wb,
                       input int xb, input int pb);
    if (s) begin
      ifb.start = st; ifb.cfg_npix = NPW'(np);
      ifb.cfg_wbase = AW'(wb); ifb.cfg_xbase = AW'(xb); ifb.cfg_pbase = AW'(pb);
    end else begin
      ifa.start = st; ifa.cfg_npix = NPW'(np);
      ifa.cfg_wbase = AW'(wb); ifa.cfg_xbase = AW'(xb); ifa.cfg_pbase = AW'(pb);
    end
  endtask

  task automatic mon_start(input bit s);
    mon_en = 1'b0;
    @(negedge clk);
    #1;
    sel = s;
    mon_en = 1'b1;
  endtask

  task automatic pulse_start(input vec_t v);
    @(posedge clk); #1 drive(v.s, 1'b1, v.npix, v.wb, v.xb, v.pb);
    @(posedge clk); #1 drive(v.s, 1'b0, v.npix, v.wb, v.xb, v.pb);
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 5000 && n_done == 0; c++) begin
      @(negedge clk); #1;
    end
    cmp_i({nm, ".done_seen"}, int'(n_done != 0), 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_pass(input string nm, input vec_t v);
    int ks = v.s ? 9 : 1;
    aq_t ex, epw, epr;
    for (int k = 0; k < ks; k++) begin
      for (int i = 0; i < 8; i++)      ex.push_back(AW'(v.wb + k * 8 + i));
      for (int p = 0; p < v.npix; p++) ex.push_back(AW'(v.xb + k * v.npix + p));
      for (int j = 0; j < v.npix; j++) epw.push_back(AW'(v.pb + k * v.npix + j));
    end
    for (int p = 0; p < v.npix; p++)
      for (int m = 0; m < ks; m++) epr.push_back(AW'(v.pb + m * v.npix + p));
    cmp_q({nm, ".xaddr"}, xq, ex);
    cmp_q({nm, ".pwaddr"}, pwq, epw);
    cmp_q({nm, ".praddr"}, prq, epr);
    cmp_i({nm, ".xlast"}, xq.size() > 0 ? int'(xq[xq.size()-1]) : -1, v.xlast);
    cmp_i({nm, ".prlast"}, prq.size() > 0 ? int'(prq[prq.size()-1]) : -1, v.prlast);
    cmp_i({nm, ".kld"}, n_kld, 8 * ks);
    cmp_i({nm, ".exec"}, n_exec, v.npix * ks);
    cmp_i({nm, ".ofifo_rd"}, n_ofrd, v.npix * ks);
    cmp_i({nm, ".l0_wr"}, n_l0wr, (8 + v.npix) * ks);
    cmp_i({nm, ".acc"}, n_acc, v.npix * ks);
    cmp_i({nm, ".done_cnt"}, n_done, 1);
    cmp_i({nm, ".latency_rules"}, n_rule, 0);
    cmp_i({nm, ".busy_after"}, int'(v.s ? ifb.busy : ifa.busy), 0);
  endtask

  initial begin
    vec_t tv[5];
    int stall_bad;
    tv[0] = '{1'b0, 4,  0,    16,   0,    19,  3};
    tv[1] = '{1'b1, 4,  0,    16,   0,    51,  35};
    tv[2] = '{1'b1, 1,  2040, 2045, 2047, 5,   7};
    tv[3] = '{1'b0, 64, 100,  200,  300,  263, 363};
    tv[4] = '{1'b1, 7,  2000, 10,   1000, 72,  1062};

    drive(1'b0, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 0);

    #12;
    cmp_i("reset.inst_a", int'(inst_a === INST_IDLE), 1);
    cmp_i("reset.inst_b", int'(inst_b === INST_IDLE), 1);
    cmp_i("reset.busy", int'(ifa.busy), 0);
    cmp_i("reset.done", int'(ifa.done), 0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_i("post_reset.inst", int'(inst_a === INST_IDLE), 1);
    cmp_i("post_reset.busy", int'(ifa.busy), 0);
    cmp_i("post_reset.done", int'(ifa.done), 0);

    for (int i = 0; i < 5; i++) begin
      mon_start(tv[i].s);
      pulse_start(tv[i]);
      wait_done($sformatf("vec%0d", i));
      check_pass($sformatf("vec%0d", i), tv[i]);
    end

    // OFIFO empty during drain: no pops, no writes, idle word, then resume.
    ofv_a = 1'b0;
    mon_start(1'b0);
    pulse_start(tv[0]);
    for (int c = 0; c < 2000 && n_exec < 4; c++) begin
      @(negedge clk); #1;
    end
    cmp_i("stall.reach_drain", n_exec, 4);
    stall_bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (inst_a !== INST_IDLE || !ifa.busy) stall_bad++;
    end
    cmp_i("stall.idle_word", stall_bad, 0);
    cmp_i("stall.ofifo_rd", n_ofrd, 0);
    cmp_i("stall.pw", pwq.size(), 0);
    ofv_a = 1'b1;
    wait_done("stall");
    check_pass("stall", tv[0]);

    // start while busy, with different cfg, must not disturb the pass.
    mon_start(1'b0);
    pulse_start(tv[0]);
    repeat (10) @(posedge clk);
    #1 drive(1'b0, 1'b1, 0, 500, 500, 500);
    @(posedge clk); #1 drive(1'b0, 1'b0, 0, 500, 500, 500);
    wait_done("busy_start");
    check_pass("busy_start", tv[0]);

    // npix=0: straight to DONE, no SRAM activity.
    mon_start(1'b0);
    @(posedge clk); #1 drive(1'b0, 1'b1, 0, 3, 3, 3);
    @(posedge clk); #1;
    cmp_i("npix0.busy_accept", int'(ifa.busy), 1);
    cmp_i("npix0.done_accept", int'(ifa.done), 0);
    drive(1'b0, 1'b0, 0, 3, 3, 3);
    @(posedge clk); #1;
    cmp_i("npix0.done_pulse", int'(ifa.done), 1);
    cmp_i("npix0.busy_drop", int'(ifa.busy), 0);
    @(posedge clk); #1;
    cmp_i("npix0.done_clear", int'(ifa.done), 0);
    repeat (2) @(negedge clk);
    #1;
    cmp_i("npix0.sram_en", xq.size() + pwq.size() + prq.size(), 0);
    cmp_i("npix0.done_cnt", n_done, 1);

    // Reset during EXEC of k=1, then a clean replay from k=0.
    mon_start(1'b1);
    pulse_start(tv[1]);
    for (int c = 0; c < 2000 && n_exec < 6; c++) begin
      @(negedge clk); #1;
    end
    cmp_i("rst_exec.in_exec", int'(inst_b[B_EXEC]), 1);
    #1 reset = 1'b0;
    #1;
    cmp_i("rst_exec.inst", int'(inst_b === INST_IDLE), 1);
    cmp_i("rst_exec.busy", int'(ifb.busy), 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    mon_start(1'b1);
    pulse_start(tv[1]);
    wait_done("replay");
    check_pass("replay", tv[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
